// File: rtl/usb_packet_arbiter_pkg.sv
// Shared types and constants for the USB packet arbiter.
package usb_packet_arbiter_package;

  typedef enum logic [1:0] {IDLE, GRANT, ABORT, DRAIN} usb_packet_arbiter_state_t;

  localparam logic [7:0] COBS_DELIMITER = 8'h00;
  localparam int         STALL_CNT_W    = 16;

endpackage

// File: rtl/usb_packet_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request searching upward
// from i_last+1 with wrap.
module rr_picker #(
  parameter int NUM_SOURCES = 3,
  parameter int IDX_W       = $clog2(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] i_req,
  input  logic [IDX_W-1:0]       i_last,
  output logic                   o_found,
  output logic [IDX_W-1:0]       o_idx
);

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    // k walks priority order; j is kept constant so request selects stay static
    for (int k = 1; k <= NUM_SOURCES; k++) begin
      for (int j = 0; j < NUM_SOURCES; j++) begin
        if (!o_found && ((int'(i_last) + k) % NUM_SOURCES == j) && i_req[j]) begin
          o_found = 1'b1;
          o_idx   = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/usb_packet_arbiter.sv
// Whole-packet round-robin arbiter onto the USB FIFO byte stream, with stall
// abort (COBS delimiter + drain). USB_PACKET_ARBITER_STATS_EN adds counters.
module usb_packet_arbiter
  import usb_packet_arbiter_package::*;
#(
  parameter  int NUM_SOURCES    = 3,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W          = $clog2(NUM_SOURCES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [8*NUM_SOURCES-1:0] s_tdata,
  input  logic [NUM_SOURCES-1:0]   s_tvalid,
  input  logic [NUM_SOURCES-1:0]   s_tlast,
  output logic [NUM_SOURCES-1:0]   s_tready,
  output logic [7:0]               m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic                     grant_valid,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     abort_pulse
`ifdef USB_PACKET_ARBITER_STATS_EN
  ,
  input  logic                      stats_clear,
  output logic [32*NUM_SOURCES-1:0] pkt_count,
  output logic [15:0]               abort_count
`endif
);

  localparam logic [STALL_CNT_W-1:0] TO    = STALL_CNT_W'(TIMEOUT_CYCLES);
  localparam bit                     TO_EN = (TIMEOUT_CYCLES != 0);

  usb_packet_arbiter_state_t r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_grant_idx, r_last_grant;
  logic [STALL_CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                   r_abort_pulse;
  logic                   w_found;
  logic [IDX_W-1:0]       w_pick;
  logic [7:0]             w_bytes [NUM_SOURCES];
  logic [7:0]             w_src_data;
  logic                   w_src_vld, w_src_last;
  logic                   w_abort_entry, w_pkt_done;

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_bytes
    assign w_bytes[g] = s_tdata[8*g +: 8];
  end

  assign w_src_data = w_bytes[r_grant_idx];
  assign w_src_vld  = s_tvalid[r_grant_idx];
  assign w_src_last = s_tlast[r_grant_idx];
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  rr_picker #(.NUM_SOURCES(NUM_SOURCES), .IDX_W(IDX_W)) u_pick (
    .i_req   (s_tvalid),
    .i_last  (r_last_grant),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    s_tready    = '0;
    m_tdata     = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_found) w_state_nxt = GRANT;
      end
      GRANT: begin
        m_tdata               = w_src_data;
        m_tvalid              = w_src_vld;
        m_tlast               = w_src_last;
        s_tready[r_grant_idx] = m_tready;
        // an accepted byte always wins over expiry; backpressure holds the count
        if (w_src_vld && m_tready) begin
          w_cnt_nxt = '0;
          if (w_src_last) w_state_nxt = IDLE;
        end else if (!w_src_vld) begin
          w_cnt_nxt = w_cnt_inc;
          if (TO_EN && w_cnt_inc == TO) w_state_nxt = ABORT;
        end
      end
      ABORT: begin
        m_tdata   = COBS_DELIMITER;
        m_tvalid  = 1'b1;
        m_tlast   = 1'b1;
        w_cnt_nxt = '0;
        if (m_tready) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        s_tready[r_grant_idx] = 1'b1;
        if (w_src_vld) begin
          w_cnt_nxt = '0;
          if (w_src_last) w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (TO_EN && w_cnt_inc == TO) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_abort_entry = (r_state == GRANT) && (w_state_nxt == ABORT);
  assign w_pkt_done    = (r_state == GRANT) && w_src_vld && m_tready && w_src_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_grant_idx   <= '0;
      r_last_grant  <= IDX_W'(NUM_SOURCES - 1);
      r_cnt         <= '0;
      r_abort_pulse <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_abort_pulse <= w_abort_entry;
      if (r_state == IDLE && w_found) begin
        r_grant_idx  <= w_pick;
        r_last_grant <= w_pick;
      end
    end
  end

  assign grant_valid = (r_state != IDLE);
  assign grant_idx   = r_grant_idx;
  assign abort_pulse = r_abort_pulse;

`ifdef USB_PACKET_ARBITER_STATS_EN
  logic [NUM_SOURCES-1:0][31:0] r_pkt_cnt;
  logic [15:0]                  r_abort_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt   <= '0;
      r_abort_cnt <= '0;
    end else if (stats_clear) begin
      r_pkt_cnt   <= '0;
      r_abort_cnt <= '0;
    end else begin
      if (w_pkt_done && r_pkt_cnt[r_grant_idx] != '1)
        r_pkt_cnt[r_grant_idx] <= r_pkt_cnt[r_grant_idx] + 1'b1;
      if (w_abort_entry && r_abort_cnt != '1)
        r_abort_cnt <= r_abort_cnt + 1'b1;
    end
  end

  assign pkt_count   = r_pkt_cnt;
  assign abort_count = r_abort_cnt;
`endif

endmodule

// File: tb/tb_usb_packet_arbiter.sv
// Bench for usb_packet_arbiter: queue-driven sources, packet/round-robin
// reference model, directed abort/backpressure/reset steps.
module tb_usb_packet_arbiter;

  localparam int NS = 3;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [8*NS-1:0] s_tdata;
  logic [NS-1:0]   s_tvalid, s_tlast, s_tready;
  logic [7:0]      m_tdata;
  logic            m_tvalid, m_tlast, m_tready;
  logic            grant_valid;
  logic [1:0]      grant_idx;
  logic            abort_pulse;
`ifdef USB_PACKET_ARBITER_STATS_EN
  logic            stats_clear;
  logic [32*NS-1:0] pkt_count;
  logic [15:0]     abort_count;
`endif

  usb_packet_arbiter #(.NUM_SOURCES(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .m_tready    (m_tready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .abort_pulse (abort_pulse)
`ifdef USB_PACKET_ARBITER_STATS_EN
    ,
    .stats_clear (stats_clear),
    .pkt_count   (pkt_count),
    .abort_count (abort_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [8:0] srcq [NS][$];   // bytes still to be offered by each source
  logic [8:0] expq [NS][$];   // bytes expected on the output per source
  bit         hold [NS];
  int         run  [NS];
  int         acc  [NS];
  int         stall_pct, rdy_pct;
  bit         force_low, chk_en, want_bubble, prev_gv;
  logic [NS-1:0] prev_req;
  int         model_g;
  int         grant_log[$];
  int         grant_cyc[$];
  int         cyc, n_abort;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_expect(input logic [NS-1:0] req, input int last);
    for (int k = 1; k <= NS; k++)
      if (req[(last + k) % NS]) return (last + k) % NS;
    return -1;
  endfunction

  task automatic add_pkt(input int src, input int len);
    logic [8:0] e;
    for (int k = 0; k < len; k++) begin
      e = {(k == len - 1), 8'($urandom)};
      srcq[src].push_back(e);
      expq[src].push_back(e);
    end
  endtask

  // One cycle: drive at negedge, then sample what the next posedge will commit.
  task automatic step();
    logic [8:0]  e;
    logic [31:0] rexp;
    int          r;
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      s_tvalid[i] = 1'b0;
      s_tlast[i]  = 1'b0;
      s_tdata[8*i +: 8] = 8'($urandom);
      if (srcq[i].size() > 0 && !hold[i]) begin
        if (stall_pct > 0 && run[i] < 3 && int'($urandom_range(99)) < stall_pct) run[i]++;
        else begin
          run[i] = 0;
          e = srcq[i][0];
          s_tvalid[i] = 1'b1;
          s_tlast[i]  = e[8];
          s_tdata[8*i +: 8] = e[7:0];
        end
      end
    end
    m_tready = !force_low && (int'($urandom_range(99)) < rdy_pct);
    #1;
    cyc++;
    if (want_bubble) begin
      chk("bubble", grant_valid, 0);
      want_bubble = 0;
    end
    if (grant_valid && !prev_gv) begin
      r = rr_expect(prev_req, model_g);
      chk("rr_idx", grant_idx, r);
      if (r < 0) r = 0;
      model_g = r;
      grant_log.push_back(r);
      grant_cyc.push_back(cyc);
    end
    if (chk_en && grant_valid) begin
      rexp = '0;
      rexp[model_g] = m_tready;
      chk("route_rdy", s_tready, rexp);
      chk("route_vld", m_tvalid, s_tvalid[model_g]);
      if (m_tvalid && m_tready) begin
        chk("beat_expected", expq[model_g].size() > 0, 1);
        if (expq[model_g].size() > 0) begin
          e = expq[model_g].pop_front();
          chk("beat_data", m_tdata, e[7:0]);
          chk("beat_last", m_tlast, e[8]);
          if (e[8]) want_bubble = 1;
        end
      end
    end
    if (abort_pulse) n_abort++;
    for (int i = 0; i < NS; i++)
      if (s_tvalid[i] && s_tready[i]) begin
        void'(srcq[i].pop_front());
        acc[i]++;
      end
    prev_req = s_tvalid;
    prev_gv  = grant_valid;
  endtask

  task automatic drain_all(input string tag, input int max);
    int  n = 0;
    int  left;
    bit  done = 0;
    while (!done && n < max) begin
      step();
      n++;
      left = 0;
      for (int i = 0; i < NS; i++) left += srcq[i].size();
      done = (left == 0) && !grant_valid;
    end
    chk(tag, done, 1);
    left = 0;
    for (int i = 0; i < NS; i++) left += expq[i].size();
    chk({tag, "_exp_left"}, left, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k0, stall_cnt, hi, nb;
    bit found, first;
    rst_n = 1'b0; s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0;
`ifdef USB_PACKET_ARBITER_STATS_EN
    stats_clear = 1'b0;
`endif
    for (int i = 0; i < NS; i++) begin hold[i] = 0; run[i] = 0; acc[i] = 0; end
    stall_pct = 0; rdy_pct = 100; force_low = 0; chk_en = 1; want_bubble = 0;
    prev_gv = 0; prev_req = '0; model_g = NS - 1; cyc = 0; n_abort = 0;

    // reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_abort_pulse", abort_pulse, 0);
    rst_n = 1'b1;

    // three simultaneous 4-byte packets: order 0,1,2, one bubble each
    k0 = grant_log.size();
    for (int i = 0; i < NS; i++) add_pkt(i, 4);
    drain_all("sc1_done", 100);
    chk("sc1_ngrants", grant_log.size() - k0, 3);
    if (grant_log.size() >= k0 + 3) begin
      for (int i = 0; i < 3; i++) chk("sc1_order", grant_log[k0 + i], i);
      chk("sc1_gap01", grant_cyc[k0 + 1] - grant_cyc[k0], 5);
      chk("sc1_gap12", grant_cyc[k0 + 2] - grant_cyc[k0 + 1], 5);
    end

    // stall abort: two bytes from source 0, then silence
    add_pkt(0, 5);
    acc[0] = 0; n = 0;
    while (acc[0] < 2 && n < 30) begin step(); n++; end
    chk("sc5_started", acc[0], 2);
    chk_en = 0; hold[0] = 1; stall_cnt = 0; found = 0; nb = n_abort; n = 0;
    while (!found && n < 40) begin
      step(); n++;
      if (m_tvalid) found = 1;
      else if (grant_valid) stall_cnt++;
    end
    chk("abort_seen", found, 1);
    chk("abort_stall_cycles", stall_cnt, TO);
    chk("abort_data", m_tdata, 8'h00);
    chk("abort_last", m_tlast, 1);
    chk("abort_pulse", abort_pulse, 1);
    chk("abort_s_tready", s_tready, 0);
    hold[0] = 0; n = 0; first = 1;
    while (srcq[0].size() > 0 && n < 30) begin
      step(); n++;
      if (first) chk("abort_pulse_once", abort_pulse, 0);
      first = 0;
      chk("drain_quiet", m_tvalid, 0);
      chk("drain_rdy", s_tready[0], 1);
    end
    chk("drain_consumed", srcq[0].size(), 0);
    step();
    chk("drain_to_idle", grant_valid, 0);
    chk("abort_pulse_count", n_abort - nb, 1);
    expq[0].delete();
    chk_en = 1;

`ifdef USB_PACKET_ARBITER_STATS_EN
    for (int i = 0; i < NS; i++) chk("stats_pkt_count", pkt_count[32*i +: 32], 1);
    chk("stats_abort_count", abort_count, 1);
    @(negedge clk); stats_clear = 1'b1;
    @(negedge clk); stats_clear = 1'b0;
    #1;
    chk("stats_pkt_clr", pkt_count, 0);
    chk("stats_abort_clr", abort_count, 0);
`endif

    // continuous source 1 against waiting source 2: strict alternation
    k0 = grant_log.size();
    for (int p = 0; p < 4; p++) add_pkt(1, 3);
    for (int p = 0; p < 3; p++) add_pkt(2, 3);
    drain_all("sc2_done", 200);
    chk("sc2_ngrants", grant_log.size() - k0, 7);
    if (grant_log.size() >= k0 + 7)
      for (int i = 0; i < 7; i++) chk("sc2_alternate", grant_log[k0 + i], (i % 2 == 0) ? 1 : 2);

    // random traffic: short stalls, random backpressure, 1..6 byte packets
    stall_pct = 25; rdy_pct = 70;
    for (int i = 0; i < NS; i++)
      for (int p = 0; p < 6; p++) add_pkt(i, int'($urandom_range(6, 1)));
    nb = n_abort;
    drain_all("rand_done", 3000);
    chk("rand_no_abort", n_abort - nb, 0);

    // long downstream backpressure mid-packet never aborts
    stall_pct = 0; rdy_pct = 100;
    add_pkt(1, 6);
    acc[1] = 0; n = 0;
    while (acc[1] < 2 && n < 30) begin step(); n++; end
    force_low = 1; nb = n_abort; hi = 0;
    repeat (100) begin step(); if (grant_valid) hi++; end
    force_low = 0;
    chk("bp_grant_held", hi, 100);
    drain_all("bp_done", 100);
    chk("bp_no_abort", n_abort - nb, 0);

    // asynchronous reset mid-packet
    add_pkt(2, 6);
    acc[2] = 0; n = 0;
    while (acc[2] < 2 && n < 30) begin step(); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_tvalid", m_tvalid, 0);
    chk("arst_m_tdata", m_tdata, 0);
    chk("arst_m_tlast", m_tlast, 0);
    chk("arst_s_tready", s_tready, 0);
    chk("arst_grant_valid", grant_valid, 0);
    chk("arst_grant_idx", grant_idx, 0);
    for (int i = 0; i < NS; i++) begin srcq[i].delete(); expq[i].delete(); end
    model_g = NS - 1; want_bubble = 0;
    repeat (2) step();
    rst_n = 1'b1;
    k0 = grant_log.size();
    add_pkt(2, 3);
    add_pkt(0, 3);
    drain_all("arst_done", 100);
    chk("arst_ngrants", grant_log.size() - k0, 2);
    if (grant_log.size() >= k0 + 2) begin
      chk("arst_first_grant", grant_log[k0], 0);
      chk("arst_second_grant", grant_log[k0 + 1], 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
